// File: rtl/tpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tpu_program_loader
// Brief    : Program-memory controller for the tekito processing unit. Owns
//            the instruction store, loads it from a host byte stream while
//            holding the processor in reset, zero-fills the unwritten tail
//            and releases the processor after a fixed delay.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_program_loader #(
  parameter int ADDR_WIDTH    = 6,
  parameter int DATA_WIDTH    = 8,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  HOST_LOAD,
  input  logic                  HOST_VALID,
  input  logic [DATA_WIDTH-1:0] HOST_DATA,
  output logic                  HOST_READY,
  input  logic                  HOST_END,
  output logic                  BUSY,
  output logic                  CPU_RESET,
  input  logic [ADDR_WIDTH-1:0] MEMORY_ADDR,
  output logic [DATA_WIDTH-1:0] MEMORY_DATA
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int DCNT_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX   = '1;
  localparam logic [DCNT_W-1:0]     DCNT_LAST = DCNT_W'(RELEASE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FILL    = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] ptr, ptr_next;
  logic [DCNT_W-1:0]     dcnt, dcnt_next;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  cpu_reset_q;

  // State, write pointer, delay counter and the registered processor reset
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state       <= S_IDLE;
      ptr         <= '0;
      dcnt        <= '0;
      cpu_reset_q <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      dcnt        <= dcnt_next;
      cpu_reset_q <= (state_next == S_RUN);
    end
  end

  // Next-state logic and memory write request; HOST_LOAD overrides everything
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    dcnt_next  = dcnt;
    mem_we     = 1'b0;
    mem_wdata  = '0;

    case (state)
      S_IDLE: begin
        if (HOST_END) begin
          state_next = S_RELEASE;
          dcnt_next  = '0;
        end
      end
      S_LOAD: begin
        if (HOST_VALID) begin
          mem_we    = 1'b1;
          mem_wdata = HOST_DATA;
          if (ptr == PTR_MAX) begin
            // Store is full: nothing left to fill, HOST_END is irrelevant
            state_next = S_RELEASE;
            ptr_next   = '0;
            dcnt_next  = '0;
          end else begin
            ptr_next = ptr + 1'b1;
            if (HOST_END) begin
              state_next = S_FILL;
            end
          end
        end else if (HOST_END) begin
          state_next = S_FILL;
        end
      end
      S_FILL: begin
        mem_we    = 1'b1;
        mem_wdata = '0;
        if (ptr == PTR_MAX) begin
          state_next = S_RELEASE;
          ptr_next   = '0;
          dcnt_next  = '0;
        end else begin
          ptr_next = ptr + 1'b1;
        end
      end
      S_RELEASE: begin
        if (dcnt == DCNT_LAST) begin
          state_next = S_RUN;
        end else begin
          dcnt_next = dcnt + 1'b1;
        end
      end
      S_RUN: begin
        state_next = S_RUN;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A new load request restarts from address 0 and drops any pending write
    if (HOST_LOAD) begin
      state_next = S_LOAD;
      ptr_next   = '0;
      dcnt_next  = '0;
      mem_we     = 1'b0;
    end
  end

  // Instruction store; reset clears every word to NOP
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_we) begin
      mem[ptr] <= mem_wdata;
    end
  end

  assign HOST_READY  = (state == S_LOAD);
  assign BUSY        = (state == S_LOAD) || (state == S_FILL) || (state == S_RELEASE);
  assign CPU_RESET   = cpu_reset_q;
  assign MEMORY_DATA = mem[MEMORY_ADDR];

endmodule
`default_nettype wire

// File: tb/tb_tpu_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_program_loader
// Brief    : Scoreboard bench for tpu_program_loader. The driver pushes
//            expected observations (per-cycle probes and CPU_RESET rise
//            cycles) into queues; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_program_loader;

  localparam int AW    = 6;
  localparam int DW    = 8;
  localparam int RD    = 2;
  localparam int DEPTH = 64;

  localparam int SEL_MEM  = 0;
  localparam int SEL_CRST = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_RDY  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          host_load;
  logic          host_valid;
  logic [DW-1:0] host_data;
  logic          host_ready;
  logic          host_end;
  logic          busy;
  logic          cpu_reset;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  typedef struct packed {
    int         cyc;
    int         sel;
    int         addr;
    logic [7:0] exp;
  } probe_t;

  probe_t     probe_q [$];
  int         rise_q  [$];
  int         cyc        = 0;
  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] model_mem [DEPTH];
  logic [7:0] prog [$];

  tpu_program_loader #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .RELEASE_DELAY(RD)
  ) dut (
    .CLOCK      (clk),
    .RESET      (rst_n),
    .HOST_LOAD  (host_load),
    .HOST_VALID (host_valid),
    .HOST_DATA  (host_data),
    .HOST_READY (host_ready),
    .HOST_END   (host_end),
    .BUSY       (busy),
    .CPU_RESET  (cpu_reset),
    .MEMORY_ADDR(mem_addr),
    .MEMORY_DATA(mem_data)
  );

  // Clock and cycle counter (cyc = number of rising edges seen)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_MEM:  return "memory_data";
      SEL_CRST: return "cpu_reset";
      SEL_BUSY: return "busy";
      default:  return "host_ready";
    endcase
  endfunction

  // Monitor: compare queued probes for this cycle and every CPU_RESET rise
  always @(negedge clk) begin : monitor
    probe_t     p;
    logic [7:0] act;
    int         er;
    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
      p = probe_q.pop_front();
      case (p.sel)
        SEL_MEM:  act = mem_data;
        SEL_CRST: act = {7'd0, cpu_reset};
        SEL_BUSY: act = {7'd0, busy};
        default:  act = {7'd0, host_ready};
      endcase
      compared++;
      if (p.cyc != cyc || act !== p.exp) begin
        mismatched++;
        $display("FAIL %s addr=%0d cycle=%0d: actual=%02h expected=%02h (queued for cycle %0d)",
                 sel_name(p.sel), p.addr, cyc, act, p.exp, p.cyc);
      end
    end
    if (cpu_reset === 1'b1 && prev_crst !== 1'b1) begin
      compared++;
      if (rise_q.size() == 0) begin
        mismatched++;
        $display("FAIL cpu_reset_rise: actual rise at cycle %0d, expected none", cyc);
      end else begin
        er = rise_q.pop_front();
        if (er != cyc) begin
          mismatched++;
          $display("FAIL cpu_reset_rise: actual cycle %0d, expected cycle %0d", cyc, er);
        end
      end
    end
    prev_crst = cpu_reset;
  end

  logic prev_crst = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void expect_probe(input int sel, input logic [7:0] e);
    probe_t p;
    p.cyc  = cyc;
    p.sel  = sel;
    p.addr = int'(mem_addr);
    p.exp  = e;
    probe_q.push_back(p);
  endfunction

  task automatic idle_inputs();
    host_load  = 1'b0;
    host_valid = 1'b0;
    host_end   = 1'b0;
    host_data  = 8'h00;
  endtask

  task automatic fill_prog_random(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
  endtask

  // While RESET is held low, sweep every address with random host inputs
  task automatic reset_check();
    for (int a = 0; a < DEPTH; a++) begin
      host_load  = 1'($urandom);
      host_valid = 1'($urandom);
      host_end   = 1'($urandom);
      host_data  = 8'($urandom);
      mem_addr   = 6'(a);
      expect_probe(SEL_MEM, 8'h00);
      if (a % 16 == 0) begin
        expect_probe(SEL_CRST, 8'h00);
        expect_probe(SEL_BUSY, 8'h00);
        expect_probe(SEL_RDY,  8'h00);
      end
      tick();
    end
  endtask

  task automatic release_reset();
    idle_inputs();
    rst_n = 1'b1;
    tick();
    expect_probe(SEL_CRST, 8'h00);
    expect_probe(SEL_BUSY, 8'h00);
    expect_probe(SEL_RDY,  8'h00);
  endtask

  // Stream prog[0..n-1] with the chosen gap pattern; returns the edge of the
  // last store write (load or fill) according to the fill-length rule
  task automatic load_program(input int n, input int gap_mode, input bit ewl,
                              input bit do_start, output int fill_done);
    int p         = 0;
    bit tog       = 1'b0;
    int last_edge = 0;
    int e;
    bit idle;
    if (do_start) begin
      host_load = 1'b1;
      tick();
      host_load = 1'b0;
    end
    expect_probe(SEL_CRST, 8'h00);
    expect_probe(SEL_BUSY, 8'h01);
    expect_probe(SEL_RDY,  8'h01);
    while (p < n) begin
      idle = (gap_mode == 1 && tog) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
      tog  = ~tog;
      mem_addr = (p > 0) ? 6'(p - 1) : 6'd0;
      expect_probe(SEL_MEM, model_mem[int'(mem_addr)]);
      expect_probe(SEL_RDY, 8'h01);
      if (idle) begin
        host_valid = 1'b0;
        host_end   = 1'b0;
        host_data  = 8'($urandom);
      end else begin
        host_valid   = 1'b1;
        host_data    = prog[p];
        host_end     = ewl && (p == n - 1);
        model_mem[p] = prog[p];
        last_edge    = cyc + 1;
        p++;
      end
      tick();
    end
    host_valid = 1'b0;
    host_end   = 1'b0;
    if (n == DEPTH || (ewl && n > 0)) begin
      e = last_edge;
    end else begin
      host_end = 1'b1;
      e        = cyc + 1;
      tick();
      host_end = 1'b0;
    end
    fill_done = e + ((n == DEPTH) ? 0 : DEPTH - n);
    expect_probe(SEL_BUSY, 8'h01);
    expect_probe(SEL_RDY,  8'h00);
    expect_probe(SEL_CRST, 8'h00);
  endtask

  task automatic wait_run(input int limit);
    int n = 0;
    while (cpu_reset !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    compared++;
    if (cpu_reset !== 1'b1) begin
      mismatched++;
      $display("FAIL wait_run: actual cpu_reset=%b after %0d cycles, expected 1", cpu_reset, limit);
    end
    expect_probe(SEL_CRST, 8'h01);
    expect_probe(SEL_BUSY, 8'h00);
    expect_probe(SEL_RDY,  8'h00);
  endtask

  task automatic readback();
    for (int a = 0; a < DEPTH; a++) begin
      mem_addr = 6'(a);
      expect_probe(SEL_MEM, model_mem[a]);
      tick();
    end
  endtask

  // Tail zero-fill in the model, expected release edge, then verify contents
  task automatic finish_program(input int n, input int fill_done);
    for (int a = n; a < DEPTH; a++) model_mem[a] = 8'h00;
    rise_q.push_back(fill_done + RD);
    wait_run(200);
    readback();
  endtask

  // Stimulus
  initial begin : driver
    int fd;
    int n;
    int e;
    rst_n    = 1'b0;
    mem_addr = '0;
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
    tick();

    // Power-on reset
    reset_check();
    release_reset();

    // Short program with HOST_END on the last byte
    prog = '{8'h84, 8'h20, 8'h00, 8'hC0, 8'hBD, 8'h44, 8'hC0, 8'hC7};
    load_program(8, 0, 1'b1, 1'b1, fd);
    finish_program(8, fd);

    // Full load, gapped every other cycle, HOST_END on the max-address byte
    prog.delete();
    for (int a = 0; a < DEPTH; a++) prog.push_back(8'(a) ^ 8'hA5);
    load_program(DEPTH, 1, 1'b1, 1'b1, fd);
    finish_program(DEPTH, fd);

    // Abort from RUN, then abort again while the fill is about to write 20
    mem_addr = 6'd0;
    expect_probe(SEL_CRST, 8'h01);
    n = $urandom_range(1, 15);
    fill_prog_random(n);
    load_program(n, 2, 1'($urandom), 1'b1, fd);
    for (int t = 0; t < 20 - n; t++) begin
      expect_probe(SEL_BUSY, 8'h01);
      expect_probe(SEL_RDY,  8'h00);
      tick();
    end
    for (int a = n; a < 20; a++) model_mem[a] = 8'h00;
    host_load = 1'b1;
    tick();
    host_load = 1'b0;
    expect_probe(SEL_CRST, 8'h00);
    expect_probe(SEL_BUSY, 8'h01);
    expect_probe(SEL_RDY,  8'h01);
    mem_addr = 6'd20;
    expect_probe(SEL_MEM, model_mem[20]);
    tick();
    mem_addr = 6'd19;
    expect_probe(SEL_MEM, model_mem[19]);
    tick();
    n = $urandom_range(1, 12);
    fill_prog_random(n);
    load_program(n, 2, 1'($urandom), 1'b0, fd);
    finish_program(n, fd);

    // Empty program
    load_program(0, 0, 1'b0, 1'b1, fd);
    finish_program(0, fd);

    // Random programs
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(0, DEPTH);
      fill_prog_random(n);
      load_program(n, $urandom_range(0, 2), 1'($urandom), 1'b1, fd);
      finish_program(n, fd);
    end

    // Reset in the middle of a load
    fill_prog_random(10);
    host_load = 1'b1;
    tick();
    host_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      host_valid = 1'b1;
      host_data  = prog[i];
      tick();
    end
    host_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = 8'h00;
    reset_check();
    release_reset();
    host_end = 1'b1;
    e = cyc + 1;
    tick();
    host_end = 1'b0;
    rise_q.push_back(e + RD);
    wait_run(200);
    readback();

    repeat (3) tick();
    compared++;
    if (rise_q.size() != 0 || probe_q.size() != 0) begin
      mismatched++;
      $display("FAIL pending_expectations: actual rises=%0d probes=%0d left, expected 0",
               rise_q.size(), probe_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time bound");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tpu_program_loader.md
# tpu_program_loader

Program-memory controller for the tekito processing unit. Owns the 64×8 instruction store and shares it between a host byte-stream writer and the processor's combinational fetch port. Holds the processor in reset while a program is loaded, zero-fills any unwritten tail (0x00 = NOP), then releases the processor after a fixed delay. Sits between the host/board interface and the processor's RESET, MEMORY_ADDR and MEMORY_DATA pins.

## Interface
- ADDR_WIDTH, 6, instruction address width; store depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, instruction width.
- RELEASE_DELAY, 2, number of cycles CPU_RESET stays low after load/fill completes (≥1).

- CLOCK  in  1  single clock, rising-edge.
- RESET  in  1  asynchronous, active-low reset.
- HOST_LOAD  in  1  load-start request, sampled each rising edge.
- HOST_VALID  in  1  HOST_DATA valid.
- HOST_DATA  in  DATA_WIDTH  instruction byte to write.
- HOST_READY  out  1  loader accepts a byte this cycle.
- HOST_END  in  1  end of program; remaining addresses are zero-filled.
- BUSY  out  1  high in LOAD, FILL, RELEASE.
- CPU_RESET  out  1  active-low reset to processor RESET pin, registered.
- MEMORY_ADDR  in  ADDR_WIDTH  processor fetch address.
- MEMORY_DATA  out  DATA_WIDTH  instruction at MEMORY_ADDR, combinational.

## Operation
- States: IDLE, LOAD, FILL, RELEASE, RUN. Write pointer PTR (ADDR_WIDTH bits), delay counter DCNT.
- IDLE: CPU_RESET low. HOST_LOAD → LOAD, PTR=0. HOST_END (without HOST_LOAD) → RELEASE with current contents.
- LOAD: HOST_READY=1. Transfer = HOST_VALID & HOST_READY at rising edge: mem[PTR]<=HOST_DATA, PTR<=PTR+1.
  - Transfer at PTR=max → RELEASE (no fill); HOST_END ignored that cycle.
  - HOST_END without transfer: PTR=0 → FILL from 0; else FILL from PTR.
  - HOST_END with transfer at PTR<max: byte written, then FILL from PTR+1.
- FILL: HOST_READY=0; mem[PTR]<=0, PTR++ each cycle; write at PTR=max → RELEASE.
- RELEASE: DCNT counts RELEASE_DELAY cycles, CPU_RESET low; then → RUN.
- RUN: CPU_RESET high, HOST_READY=0; HOST_VALID/HOST_END ignored.
- HOST_LOAD has priority in every state: next state LOAD, PTR=0, CPU_RESET low from that edge; any concurrent transfer or fill write is discarded. Memory contents not already overwritten are retained.
- MEMORY_DATA = mem[MEMORY_ADDR] at all times, including during LOAD/FILL (write visible after the writing edge).
- PTR wraps only via the max-address exit; no write past max.

## Timing
- Reset (RESET low, asynchronous): state IDLE, PTR=0, DCNT=0, all mem=0x00, CPU_RESET=0, HOST_READY=0, BUSY=0, MEMORY_DATA=0x00.
- HOST_LOAD sampled at edge N: HOST_READY=1, BUSY=1 and CPU_RESET=0 after edge N.
- Byte accepted at edge of transfer; one byte per cycle max; HOST_READY stays high throughout LOAD (no backpressure).
- FILL of K remaining addresses: K cycles.
- Last write (load or fill) at edge M: RELEASE from M; CPU_RESET rises after edge M+RELEASE_DELAY; BUSY falls same edge.
- Full 64-byte load with continuous HOST_VALID: 64 cycles + RELEASE_DELAY from first transfer to CPU_RESET high.
- RESET asserted mid-operation: immediate return to reset values, memory cleared.

## Test plan
- Reset: RESET low with random inputs → CPU_RESET=0, HOST_READY=0, BUSY=0, MEMORY_DATA=0x00 for every MEMORY_ADDR.
- Short program: HOST_LOAD, then bytes 0x84,0x20,0x00,0xC0,0xBD,0x44,0xC0,0xC7 on consecutive cycles with HOST_END on the last → 56 FILL cycles, CPU_RESET high exactly 2 cycles after final fill write; MEMORY_ADDR=4 → 0xBD, 7 → 0xC7, 8..63 → 0x00.
- Full load: 64 bytes value=address^0xA5 with HOST_VALID gapped every other cycle → no FILL, RELEASE after byte 63, readback matches, CPU_RESET high 2 cycles after last transfer.
- Abort: HOST_LOAD during RUN, then during FILL at PTR=20 → CPU_RESET drops next edge, PTR restarts at 0, fill write at 20 not performed, new bytes land from address 0.
- Empty program: HOST_LOAD then HOST_END with no data → 64 FILL cycles, all mem 0x00, then RUN.
- Mid-load reset: RESET low after 10 bytes → all outputs reset values, mem cleared, state IDLE (HOST_END alone then yields RUN with NOP program).
